crc8_frame_ctrl: RTL
====================

# crc8_frame_ctrl

Byte-level sequencer for the bit-serial CRC-8 engine (poly x^8+x^7+x^6+x^4+x^2+1 = 0xD5, MSB-first, no reflection, no final XOR). It accepts framed bytes over a valid/ready handshake and serialises each byte MSB-first into the engine. It clears the engine at frame start and reports the result at frame end, either as a generated CRC or as a pass/fail check. It sits between the byte-wide packet path and the CRC datapath in front of the serial link.

## Interface
- POLY, 8'hD5: feedback polynomial, low 8 bits; bit 8 is implicit.
- INIT, 8'h00: engine value loaded at frame start.
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- DIN  in  8  data byte.
- DIN_VALID  in  1  DIN is valid.
- DIN_LAST  in  1  DIN is the final byte of the frame. In check mode this is the received CRC byte.
- DIN_READY  out  1  block can accept a byte this cycle.
- MODE  in  1  0 = generate, 1 = check; sampled on the first byte of a frame.
- ABORT  in  1  drops the current frame.
- BUSY  out  1  a frame is in progress (first byte accepted, DONE not yet issued).
- DONE  out  1  one-cycle pulse: frame complete, results valid.
- CRC_OUT  out  8  final engine value, held until the next frame starts.
- CRC_OK  out  1  check mode: CRC_OUT == 0; generate mode: 0. Held with CRC_OUT.

## Operation
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - DIN_READY = 1.
  - On DIN_VALID: load DIN into the shift register, latch DIN_LAST, set bit counter = 7, go to SHIFT.
  - If no frame is open: load the engine with INIT, latch MODE, set BUSY, clear CRC_OUT/CRC_OK to 0.
- SHIFT:
  - DIN_READY = 0. Each cycle the engine is enabled with BITVAL = shreg[7]; shreg shifts left; the counter decrements.
  - After the 8th bit (counter was 0): go to FINISH if the latched last flag is set, else go to IDLE.
- FINISH:
  - One cycle. DONE = 1. CRC_OUT = engine value. CRC_OK = MODE_latched & (engine == 0). Clear BUSY, go to IDLE.
- Check mode relies on the residue property: data followed by its correct CRC leaves the engine at 0.
- Engine update per enabled bit: fb = BITVAL ^ crc[7]; crc = {crc[6:0],1'b0} ^ (fb ? POLY : 0).
- DIN_VALID while DIN_READY = 0 is ignored. The source must hold the byte until it sees DIN_READY = 1.
- ABORT, any state, has priority over a handshake in the same cycle:
  - Go to IDLE, clear BUSY, no DONE.
  - The engine is not touched; it is re-initialised by the next frame's first byte.
  - CRC_OUT/CRC_OK keep their previous values.
- Frames have no minimum length, so a single byte with DIN_LAST = 1 is a legal frame.
- In check mode a one-byte frame checks that byte as the CRC of an empty frame (OK iff byte == INIT).
- RESET (any time, including mid-byte):
  - State = IDLE; engine = INIT; shreg, counter and flags = 0.
  - DIN_READY = 1, BUSY = 0, DONE = 0, CRC_OUT = 8'h00, CRC_OK = 0.

## Timing
- Handshake at cycle 0 (DIN_VALID & DIN_READY).
- Bits 7..0 enter the engine on the edges ending cycles 1..8; DIN_READY = 0 in cycles 1..8.
- Non-last byte: DIN_READY = 1 in cycle 9, giving a throughput of 1 byte per 9 cycles.
- Last byte: DONE = 1 in cycle 9 with CRC_OUT/CRC_OK valid; DIN_READY = 1 in cycle 10.
- N-byte frame: DONE occurs 9·N cycles after the first handshake, if each byte is presented as soon as READY rises.
- CRC_OUT/CRC_OK change only in the FINISH cycle, at the first-byte handshake (cleared), or on RESET.

## Structure
- Shared package `crc8_pkg`:
  - CRC8_POLY_D5 = 8'hD5, CRC8_INIT = 8'h00.
  - State encoding constants (IDLE, SHIFT, FINISH).
  - MODE_GEN = 0, MODE_CHK = 1.
- One sub-module, `crc8_bit_engine` (CLK, RESET, CLEAR, ENABLE, BITVAL, CRC[7:0]).
  - Sync CLEAR loads INIT; ENABLE performs one update; CLEAR has priority over ENABLE.
  - The controller owns the FSM, shift register, counter and result registers only.

## Test plan
- Generate, single byte 8'h01, LAST = 1 -> DONE 9 cycles after the handshake, CRC_OUT = 8'hD5, CRC_OK = 0; READY low cycles 1..8.
- Generate, ASCII "123456789" (8'h31..8'h39), back-to-back on READY -> DONE at cycle 81, CRC_OUT = 8'hBC.
- Check, frame 8'h01, 8'hD5 -> CRC_OUT = 8'h00, CRC_OK = 1. Frame 8'h01, 8'hD4 -> CRC_OUT = 8'hD5, CRC_OK = 0.
- ABORT asserted in the 4th SHIFT cycle of byte 2 of "123456789", then the full frame resent -> no DONE for the aborted frame; the resent frame gives CRC_OUT = 8'hBC; BUSY low the cycle after ABORT.
- RESET asserted mid-SHIFT -> next cycle DIN_READY = 1, BUSY = 0, CRC_OUT = 8'h00; a subsequent 8'h01 frame yields 8'hD5.
- DIN_VALID held high with changing DIN during SHIFT -> only bytes sampled at READY are used; MODE toggled mid-frame has no effect on CRC_OK.

Source files
------------

// File: rtl/crc8_pkg.sv
// crc8_pkg: shared definitions for the byte-serial CRC-8 controller.
//   - default polynomial / init value for the engine
//   - controller state encoding
//   - mode encoding (generate / check)
//   - crc8_step: one MSB-first engine update
package crc8_pkg;

   localparam logic [7:0] CRC8_POLY_D5 = 8'hD5;
   localparam logic [7:0] CRC8_INIT    = 8'h00;

   localparam logic MODE_GEN = 1'b0;
   localparam logic MODE_CHK = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   // One bit of the CRC: the incoming bit is folded into the MSB, and the
   // polynomial (bit 8 implicit) is XORed in when the result is 1.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                            input logic       bitval,
                                            input logic [7:0] poly);
      logic fb;
      fb = bitval ^ crc[7];
      return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
   endfunction

endpackage

// File: rtl/crc8_bit_engine.sv
// crc8_bit_engine: bit-serial CRC-8 register.
//   CLK     in   system clock
//   RESET   in   synchronous active-high reset, loads INIT
//   CLEAR   in   synchronous load of INIT (wins over ENABLE)
//   ENABLE  in   apply one bit update with BITVAL
//   BITVAL  in   next message bit, MSB-first
//   CRC     out  current register value
module crc8_bit_engine
   import crc8_pkg::*;
#(
   parameter logic [7:0] POLY = CRC8_POLY_D5,
   parameter logic [7:0] INIT = CRC8_INIT
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CLEAR,
   input  logic       ENABLE,
   input  logic       BITVAL,
   output logic [7:0] CRC
);

   logic [7:0] crc_q;
   logic [7:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (CLEAR) begin
         crc_d = INIT;
      end else if (ENABLE) begin
         crc_d = crc8_step(crc_q, BITVAL, POLY);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         crc_q <= INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign CRC = crc_q;

endmodule

// File: rtl/crc8_frame_ctrl.sv
// crc8_frame_ctrl: byte-level sequencer for the bit-serial CRC-8 engine.
// Accepts framed bytes over valid/ready, shifts each byte MSB-first into the
// engine over 8 cycles, and reports the frame result (generate or check).
//   CLK, RESET         clock, synchronous active-high reset
//   DIN[7:0]           data byte (in check mode the last byte is the CRC)
//   DIN_VALID/READY    byte handshake
//   DIN_LAST           marks the final byte of a frame
//   MODE               0 = generate, 1 = check; taken from the first byte
//   ABORT              drop the current frame, no DONE
//   BUSY               a frame is open
//   DONE               one-cycle end-of-frame pulse
//   CRC_OUT, CRC_OK    frame result, held until the next frame starts
module crc8_frame_ctrl
   import crc8_pkg::*;
#(
   parameter logic [7:0] POLY = CRC8_POLY_D5,
   parameter logic [7:0] INIT = CRC8_INIT
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] DIN,
   input  logic       DIN_VALID,
   input  logic       DIN_LAST,
   output logic       DIN_READY,
   input  logic       MODE,
   input  logic       ABORT,
   output logic       BUSY,
   output logic       DONE,
   output logic [7:0] CRC_OUT,
   output logic       CRC_OK
);

   state_t     state_q, state_d;
   logic [7:0] shreg_q, shreg_d;
   logic [2:0] cnt_q, cnt_d;
   logic       last_q, last_d;
   logic       mode_q, mode_d;
   logic       busy_q, busy_d;
   logic [7:0] crc_out_q, crc_out_d;
   logic       crc_ok_q, crc_ok_d;

   logic       eng_clear;
   logic       eng_enable;
   logic [7:0] eng_crc;
   logic       done;

   crc8_bit_engine #(
      .POLY(POLY),
      .INIT(INIT)
   ) u_engine (
      .CLK    (CLK),
      .RESET  (RESET),
      .CLEAR  (eng_clear),
      .ENABLE (eng_enable),
      .BITVAL (shreg_q[7]),
      .CRC    (eng_crc)
   );

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      mode_d     = mode_q;
      busy_d     = busy_q;
      crc_out_d  = crc_out_q;
      crc_ok_d   = crc_ok_q;
      eng_clear  = 1'b0;
      eng_enable = 1'b0;
      done       = 1'b0;

      // ABORT overrides everything; the engine is left alone and gets
      // re-initialised by the next frame's first byte.
      if (ABORT) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (DIN_VALID) begin
                  shreg_d = DIN;
                  last_d  = DIN_LAST;
                  cnt_d   = 3'd7;
                  state_d = ST_SHIFT;
                  // busy_q low here means this byte opens a new frame.
                  if (!busy_q) begin
                     eng_clear = 1'b1;
                     mode_d    = MODE;
                     busy_d    = 1'b1;
                     crc_out_d = 8'h00;
                     crc_ok_d  = 1'b0;
                  end
               end
            end
            ST_SHIFT: begin
               eng_enable = 1'b1;
               shreg_d    = {shreg_q[6:0], 1'b0};
               cnt_d      = cnt_q - 3'd1;
               if (cnt_q == 3'd0) begin
                  state_d = last_q ? ST_FINISH : ST_IDLE;
               end
            end
            ST_FINISH: begin
               done      = 1'b1;
               crc_out_d = eng_crc;
               crc_ok_d  = (mode_q == MODE_CHK) && (eng_crc == 8'h00);
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         shreg_q   <= 8'h00;
         cnt_q     <= 3'd0;
         last_q    <= 1'b0;
         mode_q    <= 1'b0;
         busy_q    <= 1'b0;
         crc_out_q <= 8'h00;
         crc_ok_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         mode_q    <= mode_d;
         busy_q    <= busy_d;
         crc_out_q <= crc_out_d;
         crc_ok_q  <= crc_ok_d;
      end
   end

   assign DIN_READY = (state_q == ST_IDLE);
   assign BUSY      = busy_q;
   assign DONE      = done;
   // The result must already be visible in the DONE cycle, so bypass the
   // result registers while FINISH is loading them.
   assign CRC_OUT   = done ? crc_out_d : crc_out_q;
   assign CRC_OK    = done ? crc_ok_d  : crc_ok_q;

endmodule
